// File: rtl/dmem_access_ctrl.sv
// Two-port data-memory sequencer: arbitrates p0/p1, extends loads, turns SB/SH into read-modify-write.
// Latency gnt->rvalid: SW/illegal 1, load/SB/SH 2; requests are held by the requester until gnt, none granted while busy.
module dmem_access_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [DM_ADDRESS-1:0] p0_addr,
    input  logic [2:0]            p0_funct3,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_W-1:0]     p0_rdata,
    output logic                  p0_err,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [DM_ADDRESS-1:0] p1_addr,
    input  logic [2:0]            p1_funct3,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_W-1:0]     p1_rdata,
    output logic                  p1_err,
    output logic [DM_ADDRESS-1:0] mem_raddr,
    output logic [DM_ADDRESS-1:0] mem_waddr,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [3:0]            mem_wr,
    input  logic [DATA_W-1:0]     mem_rd,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, LD_RD, LD_RSP, ST_WR, RMW_RD, RMW_WR, ERR} state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    own;
    logic [DM_ADDRESS-1:0]   l_addr;
    logic [2:0]              l_f3;
    logic [DATA_W-1:0]       l_wdata;

    logic                    any_req, pick, s_we, legal;
    logic [DM_ADDRESS-1:0]   s_addr, s_word, l_word;
    logic [2:0]              s_f3;
    logic [DATA_W-1:0]       s_wdata;

    // Round-robin only matters on a tie; a lone requester always wins.
    always_comb begin
        any_req = p0_req | p1_req;
        pick    = (p0_req && p1_req) ? ~last_grant : p1_req;
        s_we    = pick ? p1_we     : p0_we;
        s_addr  = pick ? p1_addr   : p0_addr;
        s_f3    = pick ? p1_funct3 : p0_funct3;
        s_wdata = pick ? p1_wdata  : p0_wdata;
        s_word  = {s_addr[DM_ADDRESS-1:2], 2'b00};
        l_word  = {l_addr[DM_ADDRESS-1:2], 2'b00};
        legal   = 1'b0;
        case (s_f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~s_addr[0];
            3'b010:  legal = (s_addr[1:0] == 2'b00);
            3'b100:  legal = ~s_we;
            3'b101:  legal = ~s_we & ~s_addr[0];
            default: legal = 1'b0;
        endcase
    end

    logic [1:0]        lane;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [DATA_W-1:0] ld_data, rmw_data;
    logic              rsp_vld, rsp_err;
    logic [DATA_W-1:0] rsp_dat;

    always_comb begin
        lane  = l_addr[1:0];
        rbyte = mem_rd[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (l_f3)
            3'b000:  ld_data = {{24{rbyte[7]}}, rbyte};
            3'b001:  ld_data = {{16{rhalf[15]}}, rhalf};
            3'b100:  ld_data = {24'h0, rbyte};
            3'b101:  ld_data = {16'h0, rhalf};
            default: ld_data = mem_rd;
        endcase
        rmw_data = mem_rd;
        if (l_f3 == 3'b000)
            rmw_data[{lane, 3'b000} +: 8] = l_wdata[7:0];
        else if (lane[1])
            rmw_data[31:16] = l_wdata[15:0];
        else
            rmw_data[15:0] = l_wdata[15:0];
        rsp_vld = (state == LD_RSP) || (state == ST_WR) || (state == RMW_WR) || (state == ERR);
        rsp_err = (state == ERR);
        rsp_dat = (state == LD_RSP) ? ld_data : '0;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            own        <= 1'b0;
            l_addr     <= '0;
            l_f3       <= '0;
            l_wdata    <= '0;
            p0_gnt     <= 1'b0;
            p1_gnt     <= 1'b0;
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wd     <= '0;
            mem_wr     <= 4'b0000;
        end else begin
            p0_gnt    <= 1'b0;
            p1_gnt    <= 1'b0;
            p0_rvalid <= rsp_vld & ~own;
            p1_rvalid <= rsp_vld & own;
            p0_err    <= rsp_err & ~own;
            p1_err    <= rsp_err & own;
            p0_rdata  <= own ? '0 : rsp_dat;
            p1_rdata  <= own ? rsp_dat : '0;
            mem_wr    <= 4'b0000;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        p0_gnt     <= ~pick;
                        p1_gnt     <= pick;
                        last_grant <= pick;
                        own        <= pick;
                        l_addr     <= s_addr;
                        l_f3       <= s_f3;
                        l_wdata    <= s_wdata;
                        // Read address goes out with the grant so mem_rd lands in time for the T+2 response.
                        if (!legal)
                            state <= ERR;
                        else if (!s_we) begin
                            state     <= LD_RD;
                            mem_raddr <= s_word;
                        end else if (s_f3 == 3'b010)
                            state <= ST_WR;
                        else begin
                            state     <= RMW_RD;
                            mem_raddr <= s_word;
                        end
                    end
                end
                LD_RD:  state <= LD_RSP;
                RMW_RD: state <= RMW_WR;
                ST_WR: begin
                    mem_waddr <= l_word;
                    mem_wd    <= l_wdata;
                    mem_wr    <= 4'b1111;
                    state     <= IDLE;
                end
                RMW_WR: begin
                    mem_waddr <= l_word;
                    mem_wd    <= rmw_data;
                    mem_wr    <= 4'b1111;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: ops queued per port, expectations pushed at grant, popped at rvalid/write.
module tb_dmem_access_ctrl;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        err;
    } op_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        chk_dat;
        int          due;
    } exp_t;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] dat;
        int          due;
    } wexp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we;
    logic [8:0]  addr [2];
    logic [2:0]  f3 [2];
    logic [31:0] wd [2];
    wire  [1:0]  gnt, rvalid, errs;
    wire  [31:0] rdata0, rdata1;
    wire  [8:0]  mem_raddr, mem_waddr;
    wire  [31:0] mem_wd;
    wire  [3:0]  mem_wr;
    logic [31:0] mem_rd;
    wire         busy;

    logic [31:0] mem [128];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    op_t         opq [2][$];
    exp_t        exq [2][$];
    wexp_t       wq [$];
    int          glog [$];
    op_t         cur [2];

    dmem_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_funct3(f3[0]), .p0_wdata(wd[0]),
        .p0_gnt(gnt[0]), .p0_rvalid(rvalid[0]), .p0_rdata(rdata0), .p0_err(errs[0]),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_funct3(f3[1]), .p1_wdata(wd[1]),
        .p1_gnt(gnt[1]), .p1_rvalid(rvalid[1]), .p1_rdata(rdata1), .p1_err(errs[1]),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wd(mem_wd), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        mem_rd <= mem[mem_raddr[8:2]];
        if (mem_wr == 4'hF) mem[mem_waddr[8:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic op_t mk(input logic w, input logic [8:0] a, input logic [2:0] f,
                               input logic [31:0] d, input logic [31:0] e, input logic er);
        op_t o;
        o.we = w; o.addr = a; o.f3 = f; o.wd = d; o.exp = e; o.err = er;
        return o;
    endfunction

    // Response/write monitor: every rvalid and every write must match the oldest expectation.
    always @(negedge clk) begin : monitor
        logic [31:0] d;
        exp_t        e;
        wexp_t       w;
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                d = (p == 0) ? rdata0 : rdata1;
                if (rvalid[p]) begin
                    if (exq[p].size() == 0)
                        check($sformatf("p%0d_rvalid_unexpected", p), 32'd1, 32'd0);
                    else begin
                        e = exq[p].pop_front();
                        check($sformatf("p%0d_rvalid_cycle", p), cyc, e.due);
                        check($sformatf("p%0d_err", p), {31'd0, errs[p]}, {31'd0, e.err});
                        if (e.chk_dat) check($sformatf("p%0d_rdata", p), d, e.dat);
                    end
                end else begin
                    if (errs[p] || d != 32'd0)
                        check($sformatf("p%0d_idle_outputs", p), d | {31'd0, errs[p]}, 32'd0);
                    if (exq[p].size() != 0 && cyc > exq[p][0].due) begin
                        check($sformatf("p%0d_rvalid_missing", p), cyc, exq[p][0].due);
                        void'(exq[p].pop_front());
                    end
                end
            end
            if (mem_wr != 4'h0) begin
                if (wq.size() == 0)
                    check("write_unexpected", {28'd0, mem_wr}, 32'd0);
                else begin
                    w = wq.pop_front();
                    check("mem_wr_mask", {28'd0, mem_wr}, 32'hF);
                    check("mem_waddr", {23'd0, mem_waddr}, {23'd0, w.addr});
                    check("mem_wd", mem_wd, w.dat);
                    check("write_cycle", cyc, w.due);
                end
            end else if (wq.size() != 0 && cyc > wq[0].due) begin
                check("write_missing", cyc, wq[0].due);
                void'(wq.pop_front());
            end
        end
    end

    // Drives queued ops, holding each request until its grant; called and returns at a negedge.
    task automatic run_ops();
        int   n = 0;
        int   lat;
        exp_t e;
        wexp_t w;
        forever begin
            if (gnt == 2'b11) check("double_grant", {30'd0, gnt}, 32'd1);
            for (int p = 0; p < 2; p++) begin
                if (gnt[p]) begin
                    if (!req[p]) check($sformatf("p%0d_gnt_without_req", p), 32'd1, 32'd0);
                    else begin
                        glog.push_back(p);
                        lat = (cur[p].err || cur[p].f3 == 3'b010) ? 1 : 2;
                        if (cur[p].err) lat = 1;
                        else if (!cur[p].we) lat = 2;
                        e.dat = cur[p].err ? 32'd0 : cur[p].exp;
                        e.err = cur[p].err;
                        e.chk_dat = cur[p].err || !cur[p].we;
                        e.due = cyc + lat;
                        exq[p].push_back(e);
                        if (cur[p].we && !cur[p].err) begin
                            w.addr = cur[p].addr & 9'h1FC;
                            w.dat = cur[p].exp;
                            w.due = cyc + lat;
                            wq.push_back(w);
                        end
                        req[p] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && opq[p].size() != 0) begin
                    cur[p]  = opq[p].pop_front();
                    we[p]   = cur[p].we;
                    addr[p] = cur[p].addr;
                    f3[p]   = cur[p].f3;
                    wd[p]   = cur[p].wd;
                    req[p]  = 1'b1;
                end
            end
            if (req == 2'b00 && exq[0].size() == 0 && exq[1].size() == 0 && wq.size() == 0) break;
            if (n >= 400) begin
                check("run_timeout", n, 32'd0);
                req = 2'b00;
                opq[0].delete(); opq[1].delete(); exq[0].delete(); exq[1].delete(); wq.delete();
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req = 2'b00; we = 2'b00;
        for (int p = 0; p < 2; p++) begin addr[p] = '0; f3[p] = '0; wd[p] = '0; end
        repeat (2) @(negedge clk);
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid}, 32'd0);
        check("rst_err", {30'd0, errs}, 32'd0);
        check("rst_rdata", rdata0 | rdata1, 32'd0);
        check("rst_mem_wr", {28'd0, mem_wr}, 32'd0);
        check("rst_addrs", {14'd0, mem_raddr, mem_waddr}, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // store then load a full word
        opq[0].push_back(mk(1, 9'h010, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        opq[0].push_back(mk(0, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        run_ops();

        // load extension
        opq[0].push_back(mk(1, 9'h020, 3'b010, 32'h12345680, 32'h12345680, 0));
        opq[0].push_back(mk(0, 9'h020, 3'b000, 32'h0, 32'hFFFFFF80, 0));
        opq[0].push_back(mk(0, 9'h020, 3'b100, 32'h0, 32'h00000080, 0));
        opq[0].push_back(mk(0, 9'h022, 3'b001, 32'h0, 32'h00001234, 0));
        opq[0].push_back(mk(0, 9'h020, 3'b101, 32'h0, 32'h00005680, 0));
        opq[0].push_back(mk(0, 9'h021, 3'b000, 32'h0, 32'h00000056, 0));
        opq[0].push_back(mk(0, 9'h023, 3'b000, 32'h0, 32'h00000012, 0));
        opq[1].push_back(mk(1, 9'h024, 3'b010, 32'h8001F00F, 32'h8001F00F, 0));
        opq[1].push_back(mk(0, 9'h024, 3'b001, 32'h0, 32'hFFFFF00F, 0));
        opq[1].push_back(mk(0, 9'h026, 3'b001, 32'h0, 32'hFFFF8001, 0));
        opq[1].push_back(mk(0, 9'h026, 3'b101, 32'h0, 32'h00008001, 0));
        run_ops();

        // sub-word stores via read-modify-write
        opq[0].push_back(mk(1, 9'h020, 3'b010, 32'h11223344, 32'h11223344, 0));
        opq[0].push_back(mk(1, 9'h021, 3'b000, 32'h000000AB, 32'h1122AB44, 0));
        opq[0].push_back(mk(1, 9'h022, 3'b001, 32'h0000BEEF, 32'hBEEFAB44, 0));
        opq[0].push_back(mk(1, 9'h023, 3'b000, 32'hFFFFFF5A, 32'h5AEFAB44, 0));
        opq[0].push_back(mk(1, 9'h020, 3'b001, 32'h12347777, 32'h5AEF7777, 0));
        opq[0].push_back(mk(0, 9'h020, 3'b010, 32'h0, 32'h5AEF7777, 0));
        run_ops();

        // illegal / misaligned accesses
        opq[0].push_back(mk(0, 9'h022, 3'b010, 32'h0, 32'h0, 1));
        opq[0].push_back(mk(0, 9'h023, 3'b001, 32'h0, 32'h0, 1));
        opq[1].push_back(mk(1, 9'h020, 3'b100, 32'h55, 32'h0, 1));
        opq[1].push_back(mk(0, 9'h020, 3'b011, 32'h0, 32'h0, 1));
        opq[1].push_back(mk(1, 9'h021, 3'b001, 32'h1234, 32'h0, 1));
        opq[0].push_back(mk(0, 9'h021, 3'b101, 32'h0, 32'h0, 1));
        opq[0].push_back(mk(1, 9'h026, 3'b010, 32'h0, 32'h0, 1));
        run_ops();

        // both ports requesting continuously
        glog.delete();
        opq[0].push_back(mk(0, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        opq[0].push_back(mk(0, 9'h020, 3'b010, 32'h0, 32'h5AEF7777, 0));
        opq[0].push_back(mk(1, 9'h030, 3'b010, 32'hCAFE0001, 32'hCAFE0001, 0));
        opq[0].push_back(mk(0, 9'h030, 3'b010, 32'h0, 32'hCAFE0001, 0));
        opq[1].push_back(mk(0, 9'h020, 3'b010, 32'h0, 32'h5AEF7777, 0));
        opq[1].push_back(mk(0, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        opq[1].push_back(mk(0, 9'h011, 3'b100, 32'h0, 32'h000000BE, 0));
        opq[1].push_back(mk(0, 9'h024, 3'b010, 32'h0, 32'h8001F00F, 0));
        run_ops();
        check("alt_grant_count", glog.size(), 32'd8);
        for (int i = 1; i < glog.size(); i++)
            check($sformatf("alt_grant_%0d", i), glog[i], 1 - glog[i-1]);

        // reset in the middle of a read-modify-write
        opq[0].push_back(mk(1, 9'h040, 3'b010, 32'h55667788, 32'h55667788, 0));
        run_ops();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'h041; f3[0] = 3'b000; wd[0] = 32'h000000AB;
        n = 0;
        while (!gnt[0] && n < 20) begin @(negedge clk); n++; end
        check("rmw_gnt_seen", {31'd0, gnt[0]}, 32'd1);
        check("rmw_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        req[0] = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_gnt", {30'd0, gnt}, 32'd0);
        check("midrst_mem_wr", {28'd0, mem_wr}, 32'd0);
        check("midrst_raddr", {23'd0, mem_raddr}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        glog.delete();
        opq[0].push_back(mk(0, 9'h040, 3'b010, 32'h0, 32'h55667788, 0));
        opq[1].push_back(mk(0, 9'h010, 3'b010, 32'h0, 32'hDEADBEEF, 0));
        run_ops();
        check("post_rst_grant_count", glog.size(), 32'd2);
        if (glog.size() >= 1) check("post_rst_first_tie", glog[0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
